// File: rtl/cdb_pkg.sv
// Shared types and constants for the common data bus arbiter.
package cdb_pkg;

  localparam int unsigned NSRC   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ROB_W  = 3;

  localparam int unsigned SRC_ALU    = 0;
  localparam int unsigned SRC_BRANCH = 1;
  localparam int unsigned SRC_EARLY  = 2;

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] result;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO; ready is a decode of the registered count only.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  cdb_entry_t wdata,
  output cdb_entry_t head,
  output logic       empty,
  output logic       ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  cdb_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign ready   = (count < CW'(DEPTH));
  assign push_ok = push & ready & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single CDB write slot with per-source FIFOs.
module cdb_arbiter #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned ROB   = 2,
  parameter int unsigned NSRC  = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    globalReset,
  input  logic                    flush,
  input  logic [NSRC-1:0]         srcValid,
  input  logic [NSRC*(ROB+1)-1:0] srcRob,
  input  logic [NSRC*(WIDTH+1)-1:0] srcResult,
  output logic [NSRC-1:0]         srcReady,
  output logic                    cdbValid,
  output logic [ROB:0]            cdbRob,
  output logic [WIDTH:0]          cdbResult,
  output logic [NSRC-1:0]         cdbSrc
);

  import cdb_pkg::*;

  localparam int unsigned PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  cdb_entry_t      head [NSRC];
  logic [NSRC-1:0] empty;
  logic [NSRC-1:0] ready;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] rotated;
  logic [NSRC-1:0] grant;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_nxt;
  logic [PW-1:0]   win;
  logic            any;
  cdb_entry_t      sel;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    cdb_entry_t wdata;
    assign wdata.rob    = srcRob[g*(ROB+1) +: (ROB+1)];
    assign wdata.result = srcResult[g*(WIDTH+1) +: (WIDTH+1)];

    cdb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (globalReset),
      .flush (flush),
      .push  (srcValid[g]),
      .pop   (grant[g]),
      .wdata (wdata),
      .head  (head[g]),
      .empty (empty[g]),
      .ready (ready[g])
    );
  end

  assign srcReady = ready;
  assign eligible = ~empty;

  // Rotate eligibility so rr_ptr sits at bit 0, pick lowest, rotate back.
  always_comb begin
    rotated = '0;
    any     = 1'b0;
    win     = '0;
    for (int k = 0; k < int'(NSRC); k++) begin
      rotated[k] = eligible[(k + int'(rr_ptr)) % int'(NSRC)];
    end
    for (int k = int'(NSRC) - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        any = 1'b1;
        win = PW'((k + int'(rr_ptr)) % int'(NSRC));
      end
    end
  end

  always_comb begin
    grant = '0;
    sel   = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (any && (win == PW'(i))) begin
        grant[i] = 1'b1;
        sel      = head[i];
      end
    end
  end

  always_comb begin
    rr_nxt = rr_ptr;
    if (any && !flush) begin
      rr_nxt = (win == PW'(NSRC - 1)) ? '0 : win + PW'(1);
    end
  end

  // Broadcast register; idle and flushed cycles drive zeros.
  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      rr_ptr    <= '0;
      cdbValid  <= 1'b0;
      cdbRob    <= '0;
      cdbResult <= '0;
      cdbSrc    <= '0;
    end else begin
      rr_ptr <= rr_nxt;
      if (any && !flush) begin
        cdbValid  <= 1'b1;
        cdbRob    <= sel.rob;
        cdbResult <= sel.result;
        cdbSrc    <= grant;
      end else begin
        cdbValid  <= 1'b0;
        cdbRob    <= '0;
        cdbResult <= '0;
        cdbSrc    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected per-cycle broadcasts queued with stimulus.
module tb_cdb_arbiter;

  logic        clk;
  logic        globalReset;
  logic        flush;
  logic [2:0]  srcValid;
  logic [8:0]  srcRob;
  logic [95:0] srcResult;
  logic [2:0]  srcReady;
  logic        cdbValid;
  logic [2:0]  cdbRob;
  logic [31:0] cdbResult;
  logic [2:0]  cdbSrc;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        v;
    logic [2:0]  src;
    logic [2:0]  rob;
    logic [31:0] res;
    logic [2:0]  rdy;
  } exp_t;

  typedef struct {
    logic [2:0] v;
    int         ia;
    int         ib;
    int         ie;
    logic       fl;
  } stim_t;

  exp_t exp_q[$];

  cdb_arbiter #(.WIDTH(31), .ROB(2), .NSRC(3), .DEPTH(2)) dut (
    .clk         (clk),
    .globalReset (globalReset),
    .flush       (flush),
    .srcValid    (srcValid),
    .srcRob      (srcRob),
    .srcResult   (srcResult),
    .srcReady    (srcReady),
    .cdbValid    (cdbValid),
    .cdbRob      (cdbRob),
    .cdbResult   (cdbResult),
    .cdbSrc      (cdbSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] mk_rob(int s, int i);
    return 3'((s * 3 + i + 1) % 8);
  endfunction

  function automatic logic [31:0] mk_res(int s, int i);
    return 32'(32'h0000_00A0 + s * 32'h0001_0000 + i * 32'h11);
  endfunction

  function automatic exp_t exp_idle(logic [2:0] rdy);
    exp_t e;
    e     = '0;
    e.rdy = rdy;
    return e;
  endfunction

  function automatic exp_t exp_bc(int s, int i, logic [2:0] rdy);
    exp_t e;
    e.v   = 1'b1;
    e.src = 3'(1 << s);
    e.rob = mk_rob(s, i);
    e.res = mk_res(s, i);
    e.rdy = rdy;
    return e;
  endfunction

  function automatic stim_t mk_stim(logic [2:0] v, int ia, int ib, int ie, logic fl);
    stim_t st;
    st.v  = v;
    st.ia = ia;
    st.ib = ib;
    st.ie = ie;
    st.fl = fl;
    return st;
  endfunction

  task automatic drive(stim_t st);
    int idx;
    srcValid = st.v;
    flush    = st.fl;
    for (int s = 0; s < 3; s++) begin
      idx = (s == 0) ? st.ia : ((s == 1) ? st.ib : st.ie);
      srcRob[s*3 +: 3]     = mk_rob(s, idx);
      srcResult[s*32 +: 32] = mk_res(s, idx);
    end
  endtask

  task automatic do_reset();
    srcValid = '0;
    flush    = 1'b0;
    @(negedge clk);
    globalReset = 1'b1;
    @(negedge clk);
    globalReset = 1'b0;
  endtask

  task automatic test_reset();
    stim_t st[$];
    exp_t  e;
    flush = 1'b0; srcValid = '0; srcRob = '0; srcResult = '0;
    globalReset = 1'b0;
    #2 globalReset = 1'b1;
    #1;
    checks++;
    if ({cdbValid, cdbSrc, cdbRob, cdbResult} !== 39'd0) begin
      errors++;
      $display("FAIL reset_init: got v=%b src=%b rob=%0d res=%h, expected all zero", cdbValid, cdbSrc, cdbRob, cdbResult);
    end
    @(negedge clk);
    globalReset = 1'b0;
    #1;
    checks++;
    if (srcReady !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready_init: got %b expected 111", srcReady);
    end
    st.push_back(mk_stim(3'b011, 0, 0, 0, 1'b0)); exp_q.push_back(exp_idle(3'b111));
    st.push_back(mk_stim(3'b001, 1, 0, 0, 1'b0)); exp_q.push_back(exp_bc(0, 0, 3'b111));
    foreach (st[k]) begin
      drive(st[k]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({cdbValid, cdbSrc, cdbRob, cdbResult, srcReady} !== e) begin
        errors++;
        $display("FAIL reset_traffic cyc%0d: got v=%b src=%b rob=%0d res=%h rdy=%b expected v=%b src=%b rob=%0d res=%h rdy=%b",
                 k, cdbValid, cdbSrc, cdbRob, cdbResult, srcReady, e.v, e.src, e.rob, e.res, e.rdy);
      end
    end
    // Two entries now queued (ALU and branch) with a live broadcast.
    #2 globalReset = 1'b1;
    srcValid = '0;
    #1;
    checks++;
    if ({cdbValid, cdbSrc, cdbRob, cdbResult} !== 39'd0) begin
      errors++;
      $display("FAIL reset_async: got v=%b src=%b rob=%0d res=%h, expected all zero", cdbValid, cdbSrc, cdbRob, cdbResult);
    end
    #1 globalReset = 1'b0;
    #1;
    checks++;
    if (srcReady !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 111", srcReady);
    end
    for (int k = 0; k < 3; k++) exp_q.push_back(exp_idle(3'b111));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({cdbValid, cdbSrc, cdbRob, cdbResult, srcReady} !== e) begin
        errors++;
        $display("FAIL reset_quiet cyc%0d: got v=%b src=%b rob=%0d res=%h rdy=%b expected idle",
                 k, cdbValid, cdbSrc, cdbRob, cdbResult, srcReady);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    exp_q.push_back(exp_idle(3'b111));
    e = '0; e.v = 1'b1; e.src = 3'b001; e.rob = 3'd5; e.res = 32'h0000_00AA; e.rdy = 3'b111;
    exp_q.push_back(e);
    exp_q.push_back(exp_idle(3'b111));
    for (int k = 0; k < 3; k++) begin
      srcValid  = (k == 0) ? 3'b001 : 3'b000;
      srcRob    = 9'd5;
      srcResult = 96'hAA;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({cdbValid, cdbSrc, cdbRob, cdbResult, srcReady} !== e) begin
        errors++;
        $display("FAIL single cyc%0d: got v=%b src=%b rob=%0d res=%h rdy=%b expected v=%b src=%b rob=%0d res=%h rdy=%b",
                 k, cdbValid, cdbSrc, cdbRob, cdbResult, srcReady, e.v, e.src, e.rob, e.res, e.rdy);
      end
    end
  endtask

  task automatic test_round_robin();
    stim_t st[$];
    exp_t  e;
    do_reset();
    st.push_back(mk_stim(3'b111, 0, 0, 0, 1'b0)); exp_q.push_back(exp_idle(3'b111));
    st.push_back(mk_stim(3'b111, 1, 1, 1, 1'b0)); exp_q.push_back(exp_bc(0, 0, 3'b001));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_bc(1, 0, 3'b011));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_bc(2, 0, 3'b111));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_bc(0, 1, 3'b111));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_bc(1, 1, 3'b111));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_bc(2, 1, 3'b111));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_idle(3'b111));
    foreach (st[k]) begin
      drive(st[k]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({cdbValid, cdbSrc, cdbRob, cdbResult, srcReady} !== e) begin
        errors++;
        $display("FAIL round_robin cyc%0d: got v=%b src=%b rob=%0d res=%h rdy=%b expected v=%b src=%b rob=%0d res=%h rdy=%b",
                 k, cdbValid, cdbSrc, cdbRob, cdbResult, srcReady, e.v, e.src, e.rob, e.res, e.rdy);
      end
    end
  endtask

  task automatic test_backpressure();
    stim_t st[$];
    exp_t  e;
    do_reset();
    st.push_back(mk_stim(3'b111, 0, 0, 0, 1'b0)); exp_q.push_back(exp_idle(3'b111));
    st.push_back(mk_stim(3'b111, 1, 1, 1, 1'b0)); exp_q.push_back(exp_bc(0, 0, 3'b001));
    st.push_back(mk_stim(3'b010, 9, 2, 9, 1'b0)); exp_q.push_back(exp_bc(1, 0, 3'b011));
    st.push_back(mk_stim(3'b010, 9, 2, 9, 1'b0)); exp_q.push_back(exp_bc(2, 0, 3'b101));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_bc(0, 1, 3'b101));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_bc(1, 1, 3'b111));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_bc(2, 1, 3'b111));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_bc(1, 2, 3'b111));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_idle(3'b111));
    foreach (st[k]) begin
      drive(st[k]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({cdbValid, cdbSrc, cdbRob, cdbResult, srcReady} !== e) begin
        errors++;
        $display("FAIL backpressure cyc%0d: got v=%b src=%b rob=%0d res=%h rdy=%b expected v=%b src=%b rob=%0d res=%h rdy=%b",
                 k, cdbValid, cdbSrc, cdbRob, cdbResult, srcReady, e.v, e.src, e.rob, e.res, e.rdy);
      end
    end
  endtask

  task automatic test_flush();
    stim_t st[$];
    exp_t  e;
    do_reset();
    st.push_back(mk_stim(3'b111, 0, 0, 0, 1'b0)); exp_q.push_back(exp_idle(3'b111));
    st.push_back(mk_stim(3'b011, 1, 1, 9, 1'b0)); exp_q.push_back(exp_bc(0, 0, 3'b101));
    st.push_back(mk_stim(3'b111, 2, 2, 1, 1'b1)); exp_q.push_back(exp_idle(3'b111));
    st.push_back(mk_stim(3'b111, 3, 3, 2, 1'b0)); exp_q.push_back(exp_idle(3'b111));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_bc(1, 3, 3'b111));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_bc(2, 2, 3'b111));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_bc(0, 3, 3'b111));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_idle(3'b111));
    foreach (st[k]) begin
      drive(st[k]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({cdbValid, cdbSrc, cdbRob, cdbResult, srcReady} !== e) begin
        errors++;
        $display("FAIL flush cyc%0d: got v=%b src=%b rob=%0d res=%h rdy=%b expected v=%b src=%b rob=%0d res=%h rdy=%b",
                 k, cdbValid, cdbSrc, cdbRob, cdbResult, srcReady, e.v, e.src, e.rob, e.res, e.rdy);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t st[$];
    exp_t  e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      st.push_back(mk_stim(3'b001, i, 9, 9, 1'b0));
      exp_q.push_back((i == 0) ? exp_idle(3'b111) : exp_bc(0, i - 1, 3'b111));
    end
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_bc(0, 4, 3'b111));
    st.push_back(mk_stim(3'b000, 9, 9, 9, 1'b0)); exp_q.push_back(exp_idle(3'b111));
    foreach (st[k]) begin
      drive(st[k]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({cdbValid, cdbSrc, cdbRob, cdbResult, srcReady} !== e) begin
        errors++;
        $display("FAIL wrap cyc%0d: got v=%b src=%b rob=%0d res=%h rdy=%b expected v=%b src=%b rob=%0d res=%h rdy=%b",
                 k, cdbValid, cdbSrc, cdbRob, cdbResult, srcReady, e.v, e.src, e.rob, e.res, e.rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
